// File: rtl/mul_sched_if.sv
// Requester, result and multiplier-side signals of the shared-multiplier scheduler.
interface mul_sched_if;
    localparam int unsigned OP_W  = 16;
    localparam int unsigned RES_W = 19;

    // Requester operand handshake
    logic             req0_valid;
    logic             req1_valid;
    logic             req2_valid;
    logic [OP_W-1:0]  req0_a;
    logic [OP_W-1:0]  req1_a;
    logic [OP_W-1:0]  req2_a;
    logic [OP_W-1:0]  req0_b;
    logic [OP_W-1:0]  req1_b;
    logic [OP_W-1:0]  req2_b;
    logic             req0_ready;
    logic             req1_ready;
    logic             req2_ready;

    // Held results and their consume strobes
    logic             res0_valid;
    logic             res1_valid;
    logic             res2_valid;
    logic [RES_W-1:0] res0_data;
    logic [RES_W-1:0] res1_data;
    logic [RES_W-1:0] res2_data;
    logic             res0_ack;
    logic             res1_ack;
    logic             res2_ack;

    // Shared multiplier port and status
    logic [OP_W-1:0]  mul_a;
    logic [OP_W-1:0]  mul_b;
    logic             mul_exe;
    logic [RES_W-1:0] mul_result;
    logic             busy;

    modport slave (
        input  req0_valid, req1_valid, req2_valid,
        input  req0_a, req1_a, req2_a,
        input  req0_b, req1_b, req2_b,
        output req0_ready, req1_ready, req2_ready,
        output res0_valid, res1_valid, res2_valid,
        output res0_data, res1_data, res2_data,
        input  res0_ack, res1_ack, res2_ack,
        output mul_a, mul_b, mul_exe,
        input  mul_result,
        output busy
    );

    modport master (
        output req0_valid, req1_valid, req2_valid,
        output req0_a, req1_a, req2_a,
        output req0_b, req1_b, req2_b,
        input  req0_ready, req1_ready, req2_ready,
        input  res0_valid, res1_valid, res2_valid,
        input  res0_data, res1_data, res2_data,
        output res0_ack, res1_ack, res2_ack,
        input  mul_a, mul_b, mul_exe,
        output mul_result,
        input  busy
    );
endinterface

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one external 16x16 multiplier among three requesters.
// Each accepted operation takes one IDLE cycle (grant) plus one EXEC cycle (multiply).
module mul_sched (
    input  logic        m_clock,
    input  logic        p_reset,
    mul_sched_if.slave  bus
);
    localparam int unsigned N_REQ  = 3;
    localparam int unsigned OP_W   = 16;
    localparam int unsigned RES_W  = 19;
    localparam int unsigned ID_W   = 2;
    localparam int unsigned CAND_W = ID_W + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   id_q;
    logic [OP_W-1:0]   mul_a_q;
    logic [OP_W-1:0]   mul_b_q;
    logic [N_REQ-1:0]  res_valid_q;
    logic [RES_W-1:0]  res_data_q [N_REQ];

    logic [N_REQ-1:0]  req_valid_c;
    logic [N_REQ-1:0]  res_ack_c;
    logic [OP_W-1:0]   req_a_c [N_REQ];
    logic [OP_W-1:0]   req_b_c [N_REQ];
    logic [N_REQ-1:0]  eligible_c;
    logic              win_found_c;
    logic [ID_W-1:0]   win_idx_c;
    logic [N_REQ-1:0]  win_oh_c;
    logic [ID_W-1:0]   rr_next_c;
    logic [N_REQ-1:0]  id_oh_c;
    logic [N_REQ-1:0]  ready_c;
    logic              accept_c;
    logic              capture_c;
    logic              mul_exe_c;
    logic              busy_c;

    // Gather the per-requester interface signals into indexable vectors.
    assign req_valid_c = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
    assign res_ack_c   = {bus.res2_ack, bus.res1_ack, bus.res0_ack};
    assign req_a_c[0]  = bus.req0_a;
    assign req_a_c[1]  = bus.req1_a;
    assign req_a_c[2]  = bus.req2_a;
    assign req_b_c[0]  = bus.req0_b;
    assign req_b_c[1]  = bus.req1_b;
    assign req_b_c[2]  = bus.req2_b;

    // A requester whose previous result is still held cannot be granted again.
    assign eligible_c = req_valid_c & ~res_valid_q;

    // Round-robin search starting at rr, wrapping modulo the requester count.
    always_comb begin
        logic [CAND_W-1:0] cand;
        cand        = '0;
        win_found_c = 1'b0;
        win_idx_c   = '0;
        win_oh_c    = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = CAND_W'(rr_q) + CAND_W'(off);
            if (cand >= CAND_W'(N_REQ)) begin
                cand = cand - CAND_W'(N_REQ);
            end
            if (!win_found_c && eligible_c[ID_W'(cand)]) begin
                win_found_c = 1'b1;
                win_idx_c   = ID_W'(cand);
            end
        end
        win_oh_c[win_idx_c] = win_found_c;
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        rr_next_c = '0;
        case (win_idx_c)
            2'd0:    rr_next_c = 2'd1;
            2'd1:    rr_next_c = 2'd2;
            default: rr_next_c = 2'd0;
        endcase
    end

    // One-hot decode of the in-flight requester id.
    always_comb begin
        id_oh_c = '0;
        case (id_q)
            2'd0:    id_oh_c = 3'b001;
            2'd1:    id_oh_c = 3'b010;
            2'd2:    id_oh_c = 3'b100;
            default: id_oh_c = '0;
        endcase
    end

    // FSM state register.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a grant launches EXEC, EXEC always lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_found_c) state_d = EXEC;
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: grant strobes in IDLE, multiply strobe and capture in EXEC.
    always_comb begin
        ready_c   = '0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        mul_exe_c = 1'b0;
        busy_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found_c && !p_reset) begin
                    accept_c = 1'b1;
                    ready_c  = win_oh_c;
                end
            end
            EXEC: begin
                capture_c = 1'b1;
                mul_exe_c = 1'b1;
                busy_c    = 1'b1;
            end
            default: begin
                ready_c = '0;
            end
        endcase
    end

    // Latch operands, winner id and the advanced pointer on acceptance only.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            rr_q    <= '0;
            id_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (accept_c) begin
            rr_q    <= rr_next_c;
            id_q    <= win_idx_c;
            mul_a_q <= req_a_c[win_idx_c];
            mul_b_q <= req_b_c[win_idx_c];
        end
    end

    // Result slots: capture beats ack; ack on an empty slot has no effect.
    always_ff @(posedge m_clock or posedge p_reset) begin
        if (p_reset) begin
            res_valid_q <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                res_data_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (capture_c && id_oh_c[i]) begin
                    res_valid_q[i] <= 1'b1;
                    res_data_q[i]  <= bus.mul_result;
                end else if (res_ack_c[i]) begin
                    res_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // A held result must never be overwritten while its consumer acks it.
    capture_ack_collision: assert property (
        @(posedge m_clock) disable iff (p_reset)
        !(capture_c && |(id_oh_c & res_valid_q & res_ack_c))
    );

    // Drive the interface.
    assign bus.req0_ready = ready_c[0];
    assign bus.req1_ready = ready_c[1];
    assign bus.req2_ready = ready_c[2];
    assign bus.res0_valid = res_valid_q[0];
    assign bus.res1_valid = res_valid_q[1];
    assign bus.res2_valid = res_valid_q[2];
    assign bus.res0_data  = res_data_q[0];
    assign bus.res1_data  = res_data_q[1];
    assign bus.res2_data  = res_data_q[2];
    assign bus.mul_a      = mul_a_q;
    assign bus.mul_b      = mul_b_q;
    assign bus.mul_exe    = mul_exe_c;
    assign bus.busy       = busy_c;

endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench for mul_sched: directed scenarios plus a randomized run against a cycle model.
module tb_mul_sched;
    logic m_clock = 1'b0;
    logic p_reset;

    mul_sched_if bus ();

    mul_sched dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    always #5 m_clock = ~m_clock;

    int checks = 0;
    int errors = 0;

    // External multiplier: product only while strobed, junk otherwise.
    always_comb begin
        if (bus.mul_exe) begin
            bus.mul_result = 19'({16'd0, bus.mul_a} * {16'd0, bus.mul_b});
        end else begin
            bus.mul_result = 19'h2AAAA;
        end
    end

    logic [2:0]  ready_v;
    logic [2:0]  rvalid_v;
    logic [18:0] rdata_v [3];
    assign ready_v    = {bus.req2_ready, bus.req1_ready, bus.req0_ready};
    assign rvalid_v   = {bus.res2_valid, bus.res1_valid, bus.res0_valid};
    assign rdata_v[0] = bus.res0_data;
    assign rdata_v[1] = bus.res1_data;
    assign rdata_v[2] = bus.res2_data;

    function automatic logic [18:0] prod(input logic [15:0] a, input logic [15:0] b);
        longint unsigned full;
        full = longint'(a) * longint'(b);
        return 19'(full % 64'd524288);
    endfunction

    task automatic drive_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
        case (i)
            0:       begin bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; end
            1:       begin bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; end
            default: begin bus.req2_valid = v; bus.req2_a = a; bus.req2_b = b; end
        endcase
    endtask

    task automatic drive_ack(input int i, input logic v);
        case (i)
            0:       bus.res0_ack = v;
            1:       bus.res1_ack = v;
            default: bus.res2_ack = v;
        endcase
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            drive_req(i, 1'b0, 16'h0, 16'h0);
            drive_ack(i, 1'b0);
        end
    endtask

    task automatic tick();
        @(posedge m_clock);
        #1;
    endtask

    task automatic apply_reset();
        p_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        p_reset = 1'b0;
    endtask

    task automatic test_reset();
        p_reset = 1'b1;
        clear_inputs();
        drive_req(0, 1'b1, 16'h0011, 16'h0022);
        drive_req(2, 1'b1, 16'h0033, 16'h0044);
        repeat (2) @(posedge m_clock);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", ready_v); end
        checks++; if (bus.mul_exe !== 1'b0) begin errors++; $display("FAIL reset_mul_exe: got %b expected 0", bus.mul_exe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (rvalid_v !== 3'b000) begin errors++; $display("FAIL reset_res_valid: got %b expected 000", rvalid_v); end
        checks++; if ({bus.mul_a, bus.mul_b} !== 32'h0) begin errors++; $display("FAIL reset_operands: got %h expected 0", {bus.mul_a, bus.mul_b}); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rdata_v[i] !== 19'h0) begin errors++; $display("FAIL reset_res_data%0d: got %h expected 0", i, rdata_v[i]); end
        end
        tick();
        p_reset = 1'b0;
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b001) begin errors++; $display("FAIL reset_first_accept: got %b expected 001", ready_v); end
        tick();
        clear_inputs();
        @(negedge m_clock);
        checks++; if (bus.mul_exe !== 1'b1 || bus.mul_a !== 16'h0011 || bus.mul_b !== 16'h0022) begin
            errors++; $display("FAIL reset_first_exec: got exe=%b a=%h b=%h expected exe=1 a=0011 b=0022", bus.mul_exe, bus.mul_a, bus.mul_b);
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive_req(0, 1'b1, 16'd3, 16'd5);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b001 || bus.mul_exe !== 1'b0) begin errors++; $display("FAIL single_accept: got ready=%b exe=%b expected 001/0", ready_v, bus.mul_exe); end
        tick();
        drive_req(0, 1'b0, 16'd0, 16'd0);
        @(negedge m_clock);
        checks++; if (bus.mul_exe !== 1'b1 || bus.busy !== 1'b1 || ready_v !== 3'b000) begin errors++; $display("FAIL single_exec: got exe=%b busy=%b ready=%b expected 1/1/000", bus.mul_exe, bus.busy, ready_v); end
        checks++; if (bus.mul_a !== 16'd3 || bus.mul_b !== 16'd5) begin errors++; $display("FAIL single_operands: got a=%0d b=%0d expected 3/5", bus.mul_a, bus.mul_b); end
        tick();
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b001 || rdata_v[0] !== 19'd15) begin errors++; $display("FAIL single_result: got valid=%b data=%0d expected 001/15", rvalid_v, rdata_v[0]); end
        checks++; if (bus.mul_exe !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: got exe=%b busy=%b expected 0/0", bus.mul_exe, bus.busy); end
        tick();
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b001) begin errors++; $display("FAIL single_hold: got %b expected 001", rvalid_v); end
        tick();
        drive_ack(0, 1'b1);
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b001) begin errors++; $display("FAIL single_ack_same_cycle: got %b expected 001", rvalid_v); end
        tick();
        drive_ack(0, 1'b0);
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b000 || rdata_v[0] !== 19'd15) begin errors++; $display("FAIL single_after_ack: got valid=%b data=%0d expected 000/15", rvalid_v, rdata_v[0]); end
    endtask

    task automatic test_truncation();
        apply_reset();
        drive_req(1, 1'b1, 16'hFFFF, 16'hFFFF);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b010) begin errors++; $display("FAIL trunc_accept: got %b expected 010", ready_v); end
        tick();
        drive_req(1, 1'b0, 16'h0, 16'h0);
        tick();
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b010 || rdata_v[1] !== 19'h60001) begin errors++; $display("FAIL trunc_result: got valid=%b data=%h expected 010/60001", rvalid_v, rdata_v[1]); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_ready [7] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
        logic        exp_exe   [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  exp_rv    [7] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
        logic [15:0] op_a [3] = '{16'd100, 16'd200, 16'd300};
        logic [15:0] op_b [3] = '{16'd7, 16'd8, 16'd9};
        apply_reset();
        for (int i = 0; i < 3; i++) drive_req(i, 1'b1, op_a[i], op_b[i]);
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 3; i++) drive_ack(i, rvalid_v[i]);
            @(negedge m_clock);
            checks++; if (ready_v !== exp_ready[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, ready_v, exp_ready[c]); end
            checks++; if (bus.mul_exe !== exp_exe[c]) begin errors++; $display("FAIL rr_exe c%0d: got %b expected %b", c, bus.mul_exe, exp_exe[c]); end
            checks++; if (rvalid_v !== exp_rv[c]) begin errors++; $display("FAIL rr_res_valid c%0d: got %b expected %b", c, rvalid_v, exp_rv[c]); end
            for (int i = 0; i < 3; i++) begin
                if (exp_rv[c][i]) begin
                    checks++; if (rdata_v[i] !== prod(op_a[i], op_b[i])) begin errors++; $display("FAIL rr_res_data%0d c%0d: got %0d expected %0d", i, c, rdata_v[i], prod(op_a[i], op_b[i])); end
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_blocking();
        apply_reset();
        drive_req(0, 1'b1, 16'd2, 16'd4);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b001) begin errors++; $display("FAIL block_first: got %b expected 001", ready_v); end
        tick();
        drive_req(0, 1'b1, 16'd11, 16'd13);
        drive_req(2, 1'b1, 16'd6, 16'd7);
        @(negedge m_clock);
        tick();
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b100 || rvalid_v !== 3'b001 || rdata_v[0] !== 19'd8) begin
            errors++; $display("FAIL block_grant2: got ready=%b valid=%b data0=%0d expected 100/001/8", ready_v, rvalid_v, rdata_v[0]);
        end
        tick();
        drive_req(2, 1'b0, 16'h0, 16'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge m_clock);
            checks++; if (ready_v !== 3'b000) begin errors++; $display("FAIL block_no_grant c%0d: got %b expected 000", c, ready_v); end
            tick();
        end
        checks++; if (rvalid_v !== 3'b101 || rdata_v[2] !== 19'd42) begin errors++; $display("FAIL block_res2: got valid=%b data2=%0d expected 101/42", rvalid_v, rdata_v[2]); end
        drive_ack(0, 1'b1);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b000) begin errors++; $display("FAIL block_ack_not_eligible: got %b expected 000", ready_v); end
        tick();
        drive_ack(0, 1'b0);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b001 || rvalid_v !== 3'b100) begin errors++; $display("FAIL block_regrant0: got ready=%b valid=%b expected 001/100", ready_v, rvalid_v); end
        tick();
        drive_req(0, 1'b0, 16'h0, 16'h0);
        @(negedge m_clock);
        checks++; if (bus.mul_a !== 16'd11 || bus.mul_b !== 16'd13) begin errors++; $display("FAIL block_operands: got a=%0d b=%0d expected 11/13", bus.mul_a, bus.mul_b); end
        tick();
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b101 || rdata_v[0] !== 19'd143) begin errors++; $display("FAIL block_res0: got valid=%b data0=%0d expected 101/143", rvalid_v, rdata_v[0]); end
    endtask

    task automatic test_reset_abort();
        apply_reset();
        drive_req(2, 1'b1, 16'd7, 16'd9);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b100) begin errors++; $display("FAIL abort_accept: got %b expected 100", ready_v); end
        tick();
        drive_req(2, 1'b0, 16'h0, 16'h0);
        checks++; if (bus.mul_exe !== 1'b1) begin errors++; $display("FAIL abort_exec_started: got %b expected 1", bus.mul_exe); end
        p_reset = 1'b1;
        #1;
        checks++; if (bus.mul_exe !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_immediate: got exe=%b busy=%b expected 0/0", bus.mul_exe, bus.busy); end
        tick();
        p_reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge m_clock);
            checks++; if (rvalid_v !== 3'b000 || rdata_v[2] !== 19'd0) begin errors++; $display("FAIL abort_no_result c%0d: got valid=%b data2=%0d expected 000/0", c, rvalid_v, rdata_v[2]); end
            tick();
        end
        drive_req(2, 1'b1, 16'd7, 16'd9);
        @(negedge m_clock);
        tick();
        drive_req(2, 1'b0, 16'h0, 16'h0);
        tick();
        @(negedge m_clock);
        checks++; if (rvalid_v !== 3'b100 || rdata_v[2] !== 19'd63) begin errors++; $display("FAIL abort_next_served: got valid=%b data2=%0d expected 100/63", rvalid_v, rdata_v[2]); end
        // Pointer must return to 0: abort an op on requester 1, then offer 1 and 2.
        apply_reset();
        drive_req(1, 1'b1, 16'd5, 16'd6);
        @(negedge m_clock);
        tick();
        drive_req(1, 1'b0, 16'h0, 16'h0);
        p_reset = 1'b1;
        tick();
        p_reset = 1'b0;
        drive_req(1, 1'b1, 16'd3, 16'd3);
        drive_req(2, 1'b1, 16'd4, 16'd4);
        @(negedge m_clock);
        checks++; if (ready_v !== 3'b010) begin errors++; $display("FAIL abort_rr_cleared: got %b expected 010", ready_v); end
        tick();
        clear_inputs();
    endtask

    task automatic test_idle();
        apply_reset();
        drive_req(1, 1'b1, 16'h1234, 16'h0ABC);
        @(negedge m_clock);
        tick();
        drive_req(1, 1'b0, 16'h0, 16'h0);
        tick();
        drive_ack(1, 1'b1);
        tick();
        for (int c = 0; c < 10; c++) begin
            for (int i = 0; i < 3; i++) drive_ack(i, 1'($urandom_range(0, 1)));
            @(negedge m_clock);
            checks++; if (bus.mul_exe !== 1'b0 || bus.busy !== 1'b0 || ready_v !== 3'b000) begin
                errors++; $display("FAIL idle_quiet c%0d: got exe=%b busy=%b ready=%b expected 0/0/000", c, bus.mul_exe, bus.busy, ready_v);
            end
            checks++; if (bus.mul_a !== 16'h1234 || bus.mul_b !== 16'h0ABC) begin errors++; $display("FAIL idle_operands c%0d: got a=%h b=%h expected 1234/0abc", c, bus.mul_a, bus.mul_b); end
            checks++; if (rvalid_v !== 3'b000) begin errors++; $display("FAIL idle_stray_ack c%0d: got %b expected 000", c, rvalid_v); end
            tick();
        end
        clear_inputs();
        checks++; if (rdata_v[1] !== prod(16'h1234, 16'h0ABC)) begin errors++; $display("FAIL idle_res1_retained: got %h expected %h", rdata_v[1], prod(16'h1234, 16'h0ABC)); end
    endtask

    task automatic test_random();
        int          m_rr = 0;
        int          m_id = 0;
        bit          m_busy = 1'b0;
        logic [15:0] m_a = '0;
        logic [15:0] m_b = '0;
        bit          m_rv [3] = '{0, 0, 0};
        logic [18:0] m_rd [3] = '{19'd0, 19'd0, 19'd0};
        bit          rq_v [3] = '{0, 0, 0};
        logic [15:0] rq_a [3] = '{16'd0, 16'd0, 16'd0};
        logic [15:0] rq_b [3] = '{16'd0, 16'd0, 16'd0};
        bit          ack  [3] = '{0, 0, 0};
        logic [2:0]  exp_ready;
        int          k;
        apply_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!rq_v[i] && $urandom_range(0, 2) == 0) begin
                    rq_v[i] = 1'b1;
                    rq_a[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                    rq_b[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                end
                ack[i] = ($urandom_range(0, 3) == 0);
                drive_req(i, rq_v[i], rq_a[i], rq_b[i]);
                drive_ack(i, ack[i]);
            end
            exp_ready = 3'b000;
            k = -1;
            if (!m_busy) begin
                for (int off = 0; off < 3; off++) begin
                    int c;
                    c = (m_rr + off) % 3;
                    if (k < 0 && rq_v[c] && !m_rv[c]) k = c;
                end
            end
            if (k >= 0) exp_ready[k] = 1'b1;
            @(negedge m_clock);
            checks++; if (ready_v !== exp_ready) begin errors++; $display("FAIL rand_ready cyc%0d: got %b expected %b", cyc, ready_v, exp_ready); end
            checks++; if (bus.mul_exe !== m_busy || bus.busy !== m_busy) begin errors++; $display("FAIL rand_exe cyc%0d: got exe=%b busy=%b expected %b", cyc, bus.mul_exe, bus.busy, m_busy); end
            if (m_busy) begin
                checks++; if (bus.mul_a !== m_a || bus.mul_b !== m_b) begin errors++; $display("FAIL rand_operands cyc%0d: got %h/%h expected %h/%h", cyc, bus.mul_a, bus.mul_b, m_a, m_b); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++; if (rvalid_v[i] !== m_rv[i] || rdata_v[i] !== m_rd[i]) begin
                    errors++; $display("FAIL rand_res%0d cyc%0d: got valid=%b data=%h expected %b/%h", i, cyc, rvalid_v[i], rdata_v[i], m_rv[i], m_rd[i]);
                end
            end
            for (int i = 0; i < 3; i++) if (ack[i]) m_rv[i] = 1'b0;
            if (m_busy) begin
                m_rd[m_id] = prod(m_a, m_b);
                m_rv[m_id] = 1'b1;
                m_busy     = 1'b0;
            end else if (k >= 0) begin
                m_a    = rq_a[k];
                m_b    = rq_b[k];
                m_id   = k;
                m_rr   = (k + 1) % 3;
                m_busy = 1'b1;
                rq_v[k] = 1'b0;
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        p_reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_truncation();
        test_round_robin();
        test_blocking();
        test_reset_abort();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
